// File: rtl/pipe2_seq_pkg.sv
// Shared types and default widths for the stage-2 busD / register-file write sequencer.
package pipe2_seq_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        BUSD_IDLE   = 2'd0,
        BUSD_DST    = 2'd1,
        BUSD_LASTPC = 2'd2,
        BUSD_LOAD   = 2'd3
    } busd_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_NILL = 1'b1
    } state_e;

endpackage

// File: rtl/pipe2_ldq.sv
// Circular queue of outstanding load destinations with parallel address match
// against three query registers (two sources and a destination).
module pipe2_ldq #(
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [AW-1:0]            push_dst,
    input  logic                     pop,
    output logic [AW-1:0]            head_dst,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [AW-1:0]            query_a,
    input  logic [AW-1:0]            query_b,
    input  logic [AW-1:0]            query_dst,
    output logic                     match_a,
    output logic                     match_b,
    output logic                     match_dst
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    slots [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dst = slots[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            slots[wr_ptr] <= push_dst;
        end
    end

    always_comb begin
        match_a   = 1'b0;
        match_b   = 1'b0;
        match_dst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && slots[i] == query_a)   match_a   = 1'b1;
            if (valid[i] && slots[i] == query_b)   match_b   = 1'b1;
            if (valid[i] && slots[i] == query_dst) match_dst = 1'b1;
        end
    end

endmodule

// File: rtl/pipe2_busd_sequencer.sv
// Stage-2 busD arbiter and register-file write sequencer: load returns own busD,
// outstanding load destinations gate stage 2, and a return squashes the next slot.
module pipe2_busd_sequencer
    import pipe2_seq_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LDQ_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s2_valid,
    output logic                         s2_ready,
    input  logic                         s2_write_rf,
    input  logic                         s2_lastpc_to_busd,
    input  logic                         s2_dst_to_busd,
    input  logic                         s2_load,
    input  logic                         s2_nill_on_return,
    input  logic [REG_AW-1:0]            s2_dst,
    input  logic [REG_AW-1:0]            s2_src_a,
    input  logic [REG_AW-1:0]            s2_src_b,
    input  logic                         s2_src_a_used,
    input  logic                         s2_src_b_used,
    input  logic [DATA_W-1:0]            alu_result,
    input  logic [DATA_W-1:0]            last_pc,
    output logic                         ld_issue,
    input  logic                         ld_rsp_valid,
    output logic                         ld_rsp_ready,
    input  logic [DATA_W-1:0]            ld_rsp_data,
    output logic [1:0]                   busd_sel,
    output logic                         rf_we,
    output logic [REG_AW-1:0]            rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic                         nill_next,
    output logic [$clog2(LDQ_DEPTH):0]   ldq_count
);

    state_e            state;
    state_e            state_next;
    busd_sel_e         sel;
    logic              q_full;
    logic              q_empty;
    logic [REG_AW-1:0] head_dst;
    logic              match_a;
    logic              match_b;
    logic              match_dst;
    logic              ld_take;
    logic              squash;
    logic              wr_req;
    logic              raw_a;
    logic              raw_b;
    logic              hazard;
    logic              accept;
    logic              wr_take;

    pipe2_ldq #(
        .DEPTH (LDQ_DEPTH),
        .AW    (REG_AW)
    ) u_ldq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ld_issue),
        .push_dst  (s2_dst),
        .pop       (ld_take),
        .head_dst  (head_dst),
        .full      (q_full),
        .empty     (q_empty),
        .count     (ldq_count),
        .query_a   (s2_src_a),
        .query_b   (s2_src_b),
        .query_dst (s2_dst),
        .match_a   (match_a),
        .match_b   (match_b),
        .match_dst (match_dst)
    );

    assign ld_take = ld_rsp_valid & ~q_empty;
    assign squash  = (state == ST_NILL);
    assign wr_req  = s2_valid & s2_write_rf & (s2_lastpc_to_busd | s2_dst_to_busd);

    // A source is also unsafe while its producer is still in the RF write register.
    assign raw_a  = s2_src_a_used & (match_a | (rf_we & (rf_waddr == s2_src_a)));
    assign raw_b  = s2_src_b_used & (match_b | (rf_we & (rf_waddr == s2_src_b)));
    assign hazard = (wr_req & ld_take) | raw_a | raw_b
                  | (match_dst & (s2_write_rf | s2_load))
                  | (s2_load & q_full);

    assign s2_ready     = rst_n & (~s2_valid | squash | ~hazard);
    assign accept       = s2_valid & s2_ready;
    assign wr_take      = accept & wr_req & ~squash;
    assign ld_issue     = accept & s2_load & ~squash;
    assign ld_rsp_ready = rst_n & ~q_empty;
    assign nill_next    = squash;
    assign busd_sel     = sel;

    always_comb begin
        sel = BUSD_IDLE;
        if (ld_take) begin
            sel = BUSD_LOAD;
        end else if (wr_take) begin
            sel = s2_lastpc_to_busd ? BUSD_LASTPC : BUSD_DST;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_RUN) begin
            if (accept && s2_nill_on_return) state_next = ST_NILL;
        end else begin
            if (s2_valid) state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (ld_take) begin
            rf_we    <= 1'b1;
            rf_waddr <= head_dst;
            rf_wdata <= ld_rsp_data;
        end else if (wr_take) begin
            rf_we    <= 1'b1;
            rf_waddr <= s2_dst;
            rf_wdata <= s2_lastpc_to_busd ? last_pc : alu_result;
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule
